// File: rtl/core_wb_arb.sv
// Write-back port arbiter: shares the register-file write port between pipeline results and L1D load returns.
// Optional CORE_WB_ARB_HAZ_EN: precise per-register pending-load hazard instead of a conservative one.
module core_wb_arb #(
  parameter int unsigned LQ_DEPTH = 2,
  parameter int unsigned LQ_PTR_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_valid_in,
  input  logic                pipe_we_in,
  input  logic                pipe_is_load_in,
  input  logic [4:0]          pipe_rd_in,
  input  logic [2:0]          pipe_sx_op_in,
  input  logic [31:0]         pipe_data_in,
  input  logic                lid_ack_in,
  input  logic [31:0]         lid_data_in,
  output logic                lid_rdy_out,
  output logic                rf_we_out,
  output logic [4:0]          rf_rd_out,
  output logic [31:0]         rf_data_out,
  output logic                stall_out,
  output logic [LQ_PTR_W:0]   lq_count_out,
  output logic                err_out,
  input  logic [4:0]          haz_rs1_in,
  input  logic [4:0]          haz_rs2_in,
  output logic                haz_pend_out
);

  localparam logic [2:0] WB_SX_BP = 3'd0;
  localparam logic [2:0] WB_SX_UB = 3'd1;
  localparam logic [2:0] WB_SX_B  = 3'd2;
  localparam logic [2:0] WB_SX_H  = 3'd3;
  localparam logic [2:0] WB_SX_UH = 3'd4;
  localparam int unsigned CNT_W = LQ_PTR_W + 1;

  logic [4:0]          lq_rd [LQ_DEPTH];
  logic [2:0]          lq_sx [LQ_DEPTH];
  logic [LQ_PTR_W-1:0] head_ptr;
  logic [LQ_PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0]    lq_count;
  logic                hold_valid;
  logic [4:0]          hold_rd;
  logic [31:0]         hold_data;
  logic                lq_empty;
  logic                lq_full;
  logic                accept;
  logic                push;
  logic                pipe_wr;
  logic                pop;
  logic                spurious;
  logic                sel_valid;
  logic [4:0]          sel_rd;
  logic [31:0]         sel_data;

  function automatic logic [31:0] sx_extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      WB_SX_BP: sx_extend = d;
      WB_SX_UB: sx_extend = {24'd0, d[7:0]};
      WB_SX_B:  sx_extend = {{24{d[7]}}, d[7:0]};
      WB_SX_H:  sx_extend = {{16{d[15]}}, d[15:0]};
      WB_SX_UH: sx_extend = {16'd0, d[15:0]};
      default:  sx_extend = d;
    endcase
  endfunction

  assign lq_empty     = (lq_count == '0);
  assign lq_full      = (lq_count == CNT_W'(LQ_DEPTH));
  assign stall_out    = hold_valid | (pipe_valid_in & pipe_is_load_in & lq_full);
  assign lid_rdy_out  = ~hold_valid;
  assign accept       = pipe_valid_in & ~stall_out;
  assign push         = accept & pipe_is_load_in;
  assign pipe_wr      = accept & ~pipe_is_load_in & pipe_we_in;
  assign pop          = lid_ack_in & lid_rdy_out & ~lq_empty;
  assign spurious     = lid_ack_in & lq_empty;
  assign lq_count_out = lq_count;

  // Port priority: held write, then load return, then pipeline.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = 32'd0;
    if (hold_valid) begin
      sel_valid = 1'b1;
      sel_rd    = hold_rd;
      sel_data  = hold_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = lq_rd[head_ptr];
      sel_data  = sx_extend(lq_sx[head_ptr], lid_data_in);
    end else if (pipe_wr) begin
      sel_valid = 1'b1;
      sel_rd    = pipe_rd_in;
      sel_data  = pipe_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_out   <= 1'b0;
      rf_rd_out   <= 5'd0;
      rf_data_out <= 32'd0;
    end else begin
      rf_we_out <= sel_valid & (sel_rd != 5'd0);
      if (sel_valid) begin
        rf_rd_out   <= sel_rd;
        rf_data_out <= sel_data;
      end
    end
  end

  // A pipeline write that collides with a load return waits one cycle here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_rd    <= 5'd0;
      hold_data  <= 32'd0;
    end else if (hold_valid) begin
      hold_valid <= 1'b0;
    end else if (pipe_wr & pop) begin
      hold_valid <= 1'b1;
      hold_rd    <= pipe_rd_in;
      hold_data  <= pipe_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      lq_count <= '0;
      err_out  <= 1'b0;
    end else begin
      if (push) tail_ptr <= tail_ptr + LQ_PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + LQ_PTR_W'(1);
      if (push & ~pop)      lq_count <= lq_count + CNT_W'(1);
      else if (pop & ~push) lq_count <= lq_count - CNT_W'(1);
      if (spurious) err_out <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[tail_ptr] <= pipe_rd_in;
      lq_sx[tail_ptr] <= pipe_sx_op_in;
    end
  end

`ifdef CORE_WB_ARB_HAZ_EN
  logic [LQ_PTR_W-1:0] lq_offs;

  // Live entries plus this cycle's push, minus this cycle's pop.
  always_comb begin
    haz_pend_out = 1'b0;
    lq_offs      = '0;
    for (int i = 0; i < int'(LQ_DEPTH); i++) begin
      lq_offs = LQ_PTR_W'(i) - head_ptr;
      if (({1'b0, lq_offs} < lq_count) && !(pop && (lq_offs == '0)) &&
          (lq_rd[i] != 5'd0) && ((lq_rd[i] == haz_rs1_in) || (lq_rd[i] == haz_rs2_in)))
        haz_pend_out = 1'b1;
    end
    if (push && (pipe_rd_in != 5'd0) &&
        ((pipe_rd_in == haz_rs1_in) || (pipe_rd_in == haz_rs2_in)))
      haz_pend_out = 1'b1;
  end
`else
  logic unused_haz_rs;

  assign unused_haz_rs = ^{haz_rs1_in, haz_rs2_in};
  assign haz_pend_out  = (lq_count != '0);
`endif

endmodule

// File: tb/tb_core_wb_arb.sv
// Bench for core_wb_arb: directed vector table, reset sequence, then random traffic against a queue model.
module tb_core_wb_arb;

  localparam int LQD = 2;

  logic        clk;
  logic        rst;
  logic        pipe_valid_in, pipe_we_in, pipe_is_load_in;
  logic [4:0]  pipe_rd_in;
  logic [2:0]  pipe_sx_op_in;
  logic [31:0] pipe_data_in;
  logic        lid_ack_in;
  logic [31:0] lid_data_in;
  logic        lid_rdy_out, rf_we_out, stall_out, err_out, haz_pend_out;
  logic [4:0]  rf_rd_out;
  logic [31:0] rf_data_out;
  logic [1:0]  lq_count_out;
  logic [4:0]  haz_rs1_in, haz_rs2_in;

  int n_vec  = 0;
  int n_fail = 0;

  core_wb_arb dut (
    .clk(clk), .rst(rst),
    .pipe_valid_in(pipe_valid_in), .pipe_we_in(pipe_we_in), .pipe_is_load_in(pipe_is_load_in),
    .pipe_rd_in(pipe_rd_in), .pipe_sx_op_in(pipe_sx_op_in), .pipe_data_in(pipe_data_in),
    .lid_ack_in(lid_ack_in), .lid_data_in(lid_data_in), .lid_rdy_out(lid_rdy_out),
    .rf_we_out(rf_we_out), .rf_rd_out(rf_rd_out), .rf_data_out(rf_data_out),
    .stall_out(stall_out), .lq_count_out(lq_count_out), .err_out(err_out),
    .haz_rs1_in(haz_rs1_in), .haz_rs2_in(haz_rs2_in), .haz_pend_out(haz_pend_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, we, ld;
    logic [4:0]  rd;
    logic [2:0]  sx;
    logic [31:0] d;
    logic        ack;
    logic [31:0] ad;
    logic [4:0]  rs1, rs2;
    logic        e_stall, e_rdy, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_err, e_hz_en, e_hz_dis;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] sx;
  } ent_t;

  vec_t tbl[32];

  function automatic vec_t r(
    input logic [31:0] v, we, ld, rd, sx, d, ack, ad, rs1, rs2,
    input logic [31:0] st, rdy, ewe, erd, edata, cnt, err, hen, hdis);
    vec_t x;
    x.v = v[0]; x.we = we[0]; x.ld = ld[0]; x.rd = rd[4:0]; x.sx = sx[2:0]; x.d = d;
    x.ack = ack[0]; x.ad = ad; x.rs1 = rs1[4:0]; x.rs2 = rs2[4:0];
    x.e_stall = st[0]; x.e_rdy = rdy[0]; x.e_we = ewe[0]; x.e_rd = erd[4:0]; x.e_data = edata;
    x.e_cnt = cnt[1:0]; x.e_err = err[0]; x.e_hz_en = hen[0]; x.e_hz_dis = hdis[0];
    return x;
  endfunction

  // Extension written from the code table: 1=UB 2=B 3=H 4=UH, anything else unchanged.
  function automatic logic [31:0] ref_ext(input logic [2:0] sx, input logic [31:0] d);
    case (sx)
      3'd1: return d & 32'h0000_00FF;
      3'd2: return (d & 32'h0000_00FF) | (d[7] ? 32'hFFFF_FF00 : 32'h0);
      3'd3: return (d & 32'h0000_FFFF) | (d[15] ? 32'hFFFF_0000 : 32'h0);
      3'd4: return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, we, ld, input logic [4:0] rd, input logic [2:0] sx,
                       input logic [31:0] d, input logic ack, input logic [31:0] ad,
                       input logic [4:0] rs1, rs2);
    pipe_valid_in = v; pipe_we_in = we; pipe_is_load_in = ld; pipe_rd_in = rd;
    pipe_sx_op_in = sx; pipe_data_in = d; lid_ack_in = ack; lid_data_in = ad;
    haz_rs1_in = rs1; haz_rs2_in = rs2;
  endtask

  // Random-phase reference state.
  ent_t        q[$];
  logic        m_hold;
  logic [4:0]  m_hrd;
  logic [31:0] m_hdata;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_err;

  initial begin
    logic        e_stall, e_rdy, take, ret, sp, hz, w;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    ent_t        e;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset rf_we", 32'(rf_we_out), 0);
    chk("reset rf_rd", 32'(rf_rd_out), 0);
    chk("reset rf_data", rf_data_out, 0);
    chk("reset count", 32'(lq_count_out), 0);
    chk("reset err", 32'(err_out), 0);
    chk("reset stall", 32'(stall_out), 0);
    chk("reset rdy", 32'(lid_rdy_out), 1);
    chk("reset haz", 32'(haz_pend_out), 0);
    @(negedge clk);
    rst = 1'b0;

    //          v we ld rd sx data            ack ackdata           rs1 rs2 | st rdy we rd data        cnt err hen hdis
    tbl[0]  = r(1, 1, 0, 5, 0, 32'h1234,      0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[1]  = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 5, 32'h1234,    0, 0, 0, 0);
    tbl[2]  = r(1, 0, 1, 7, 2, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[3]  = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           1, 0, 0, 1);
    tbl[4]  = r(0, 0, 0, 0, 0, 0,             1, 32'h0000_00F0,     0, 0,     0, 1, 0, 0, 0,           1, 0, 0, 1);
    tbl[5]  = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 7, 32'hFFFF_FFF0, 0, 0, 0, 0);
    tbl[6]  = r(1, 0, 1, 3, 4, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[7]  = r(1, 1, 0, 4, 0, 32'h55,        1, 32'hABCD_8001,     0, 0,     0, 1, 0, 0, 0,           1, 0, 0, 1);
    tbl[8]  = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     1, 0, 1, 3, 32'h0000_8001, 0, 0, 0, 0);
    tbl[9]  = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 4, 32'h55,      0, 0, 0, 0);
    tbl[10] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[11] = r(1, 0, 1, 1, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[12] = r(1, 0, 1, 2, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           1, 0, 0, 1);
    tbl[13] = r(1, 0, 1, 6, 0, 0,             0, 0,                 0, 0,     1, 1, 0, 0, 0,           2, 0, 0, 1);
    tbl[14] = r(1, 0, 1, 6, 0, 0,             1, 32'h11,            0, 0,     1, 1, 0, 0, 0,           2, 0, 0, 1);
    tbl[15] = r(1, 0, 1, 6, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 1, 32'h11,      1, 0, 0, 1);
    tbl[16] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           2, 0, 0, 1);
    tbl[17] = r(0, 0, 0, 0, 0, 0,             1, 32'h22,            0, 0,     0, 1, 0, 0, 0,           2, 0, 0, 1);
    tbl[18] = r(0, 0, 0, 0, 0, 0,             1, 32'h33,            0, 0,     0, 1, 1, 2, 32'h22,      1, 0, 0, 1);
    tbl[19] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 6, 32'h33,      0, 0, 0, 0);
    tbl[20] = r(0, 0, 0, 0, 0, 0,             1, 32'h99,            0, 0,     0, 1, 0, 0, 0,           0, 0, 0, 0);
    tbl[21] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 1, 0, 0);
    tbl[22] = r(1, 0, 1, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 1, 0, 0);
    tbl[23] = r(0, 0, 0, 0, 0, 0,             1, 32'h77,            0, 0,     0, 1, 0, 0, 0,           1, 1, 0, 1);
    tbl[24] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 1, 0, 0);
    tbl[25] = r(1, 0, 1, 9, 0, 0,             0, 0,                 0, 9,     0, 1, 0, 0, 0,           0, 1, 1, 0);
    tbl[26] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 9,     0, 1, 0, 0, 0,           1, 1, 1, 1);
    tbl[27] = r(0, 0, 0, 0, 0, 0,             0, 0,                 10, 10,   0, 1, 0, 0, 0,           1, 1, 0, 1);
    tbl[28] = r(0, 0, 0, 0, 0, 0,             1, 32'h5,             0, 9,     0, 1, 0, 0, 0,           1, 1, 0, 1);
    tbl[29] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 1, 9, 32'h5,       0, 1, 0, 0);
    tbl[30] = r(1, 1, 0, 0, 0, 32'hAA,        0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 1, 0, 0);
    tbl[31] = r(0, 0, 0, 0, 0, 0,             0, 0,                 0, 0,     0, 1, 0, 0, 0,           0, 1, 0, 0);

    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      drive(tbl[k].v, tbl[k].we, tbl[k].ld, tbl[k].rd, tbl[k].sx, tbl[k].d,
            tbl[k].ack, tbl[k].ad, tbl[k].rs1, tbl[k].rs2);
      @(negedge clk);
      chk($sformatf("row%0d stall", k), 32'(stall_out), 32'(tbl[k].e_stall));
      chk($sformatf("row%0d rdy", k), 32'(lid_rdy_out), 32'(tbl[k].e_rdy));
      chk($sformatf("row%0d rf_we", k), 32'(rf_we_out), 32'(tbl[k].e_we));
      if (tbl[k].e_we) begin
        chk($sformatf("row%0d rf_rd", k), 32'(rf_rd_out), 32'(tbl[k].e_rd));
        chk($sformatf("row%0d rf_data", k), rf_data_out, tbl[k].e_data);
      end
      chk($sformatf("row%0d count", k), 32'(lq_count_out), 32'(tbl[k].e_cnt));
      chk($sformatf("row%0d err", k), 32'(err_out), 32'(tbl[k].e_err));
`ifdef CORE_WB_ARB_HAZ_EN
      chk($sformatf("row%0d haz", k), 32'(haz_pend_out), 32'(tbl[k].e_hz_en));
`else
      chk($sformatf("row%0d haz", k), 32'(haz_pend_out), 32'(tbl[k].e_hz_dis));
`endif
    end

    // Reset asserted mid-queue, between clock edges.
    @(posedge clk); #1; drive(1, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; drive(1, 1, 0, 12, 0, 32'hDEAD, 0, 0, 0, 0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("prerst rf_we", 32'(rf_we_out), 1);
    chk("prerst count", 32'(lq_count_out), 1);
    chk("prerst err", 32'(err_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst rf_we", 32'(rf_we_out), 0);
    chk("midrst rf_rd", 32'(rf_rd_out), 0);
    chk("midrst rf_data", rf_data_out, 0);
    chk("midrst count", 32'(lq_count_out), 0);
    chk("midrst err", 32'(err_out), 0);
    @(negedge clk);
    rst = 1'b0;

    q.delete();
    m_hold = 0; m_hrd = 0; m_hdata = 0; m_we = 0; m_rd = 0; m_data = 0; m_err = 0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4),
            5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 4), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      e_stall = m_hold || (pipe_valid_in && pipe_is_load_in && q.size() == LQD);
      e_rdy   = !m_hold;
      take    = pipe_valid_in && !e_stall;
      ret     = lid_ack_in && e_rdy && q.size() > 0;
      sp      = lid_ack_in && q.size() == 0;
`ifdef CORE_WB_ARB_HAZ_EN
      hz = 0;
      for (int i = 0; i < q.size(); i++)
        if (!(ret && i == 0) && q[i].rd != 0 && (q[i].rd == haz_rs1_in || q[i].rd == haz_rs2_in))
          hz = 1;
      if (take && pipe_is_load_in && pipe_rd_in != 0 &&
          (pipe_rd_in == haz_rs1_in || pipe_rd_in == haz_rs2_in))
        hz = 1;
`else
      hz = (q.size() != 0);
`endif
      chk("rnd stall", 32'(stall_out), 32'(e_stall));
      chk("rnd rdy", 32'(lid_rdy_out), 32'(e_rdy));
      chk("rnd haz", 32'(haz_pend_out), 32'(hz));
      chk("rnd rf_we", 32'(rf_we_out), 32'(m_we));
      if (m_we) begin
        chk("rnd rf_rd", 32'(rf_rd_out), 32'(m_rd));
        chk("rnd rf_data", rf_data_out, m_data);
      end
      chk("rnd count", 32'(lq_count_out), 32'(q.size()));
      chk("rnd err", 32'(err_out), 32'(m_err));

      w = 0; w_rd = 0; w_data = 0;
      if (m_hold) begin
        w = 1; w_rd = m_hrd; w_data = m_hdata; m_hold = 0;
      end else if (ret) begin
        e = q.pop_front();
        w = 1; w_rd = e.rd; w_data = ref_ext(e.sx, lid_data_in);
        if (take && !pipe_is_load_in && pipe_we_in) begin
          m_hold = 1; m_hrd = pipe_rd_in; m_hdata = pipe_data_in;
        end
      end else if (take && !pipe_is_load_in && pipe_we_in) begin
        w = 1; w_rd = pipe_rd_in; w_data = pipe_data_in;
      end
      if (take && pipe_is_load_in) begin
        e.rd = pipe_rd_in; e.sx = pipe_sx_op_in;
        q.push_back(e);
      end
      if (sp) m_err = 1;
      m_we = w && (w_rd != 0);
      if (w) begin
        m_rd = w_rd; m_data = w_data;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_arb.md
Name: core_wb_arb

Overview:
- Arbitration controller for the single register-file write port at the write-back stage.
- Shares the port between in-order pipeline results (ALU/imm/PC, already extended) and load data returned by L1D.
- A small pending-load queue holds rd/extension op for each issued load; returned data is sign/zero-extended and written when the L1D ack arrives.
- Generates pipeline stall and L1D back-pressure.

Parameters:
- LQ_DEPTH, 2, pending-load queue entries (power of 2, >=2).
- LQ_PTR_W, 1, log2(LQ_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pipe_valid_in  in  1  WB-stage instruction valid.
- pipe_we_in  in  1  instruction writes rd (non-load).
- pipe_is_load_in  in  1  instruction is a load; enqueue, no write now.
- pipe_rd_in  in  5  destination register.
- pipe_sx_op_in  in  3  WB_SX_* extension code for loads.
- pipe_data_in  in  32  final result for non-load writes.
- lid_ack_in  in  1  L1D load data valid.
- lid_data_in  in  32  L1D load data.
- lid_rdy_out  out  1  port can accept lid_ack_in this cycle.
- rf_we_out  out  1  register-file write enable (registered).
- rf_rd_out  out  5  write address (registered).
- rf_data_out  out  32  write data (registered).
- stall_out  out  1  hold WB stage; pipe inputs not consumed.
- lq_count_out  out  LQ_PTR_W+1  pending loads.
- err_out  out  1  sticky: ack with empty queue.
- haz_rs1_in, haz_rs2_in  in  5 each  decode source registers.
- haz_pend_out  out  1  source depends on a pending load.

Behaviour:
- Reset (async, rst=1): queue empty, pointers 0, hold register invalid, rf_we_out=0, rf_rd_out=0, rf_data_out=0, err_out=0, lq_count_out=0.
- Write-port priority per cycle: hold register > L1D return > pipeline write.
- All rf_* outputs registered: a write selected in cycle N appears on rf_* in cycle N+1 for exactly one cycle.
- Pipeline accept: accepted = pipe_valid_in & !stall_out.
- stall_out = hold_valid | (pipe_valid_in & pipe_is_load_in & lq_full). Combinational.
- lid_rdy_out = !hold_valid.
- Load accepted: push {rd, sx_op}; no write issued.
- Non-load accepted with pipe_we_in:
  - If no L1D return fires this cycle, write {rd, data}.
  - If an L1D return fires the same cycle, capture the write in the hold register (hold_valid=1). The hold register drains next cycle with top priority; L1D is back-pressured meanwhile.
- L1D return fires when lid_ack_in & lid_rdy_out & !lq_empty:
  - Pop head and write head.rd.
  - Data extended by head.sx_op: BP=data; UB=zero-ext [7:0]; B=sign-ext [7:0]; H=sign-ext [15:0]; UH=zero-ext [15:0]; any other code=data unmodified.
- lid_ack_in with lq_empty: data dropped, no write, err_out set until reset.
- rd==0: entry popped or accepted normally, rf_we_out forced 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full queue with a pop in the same cycle: push still stalls (no same-cycle reuse).
- Pointers wrap modulo LQ_DEPTH.
- Loads return in issue order (FIFO).

Optional Feature:
- Macro: CORE_WB_ARB_HAZ_EN.
- Defined: haz_pend_out = OR over valid queue entries of (entry.rd != 0 & (entry.rd == haz_rs1_in | entry.rd == haz_rs2_in)). Includes a same-cycle push, excludes a same-cycle pop.
- Undefined: haz_pend_out = (lq_count_out != 0), a conservative stall; haz_rs*_in are ignored.

Test Plan:
- Non-load: pipe_valid=1, we=1, rd=5, data=0x1234 with no ack -> next cycle rf_we=1, rd=5, data=0x1234; stall_out=0 throughout.
- Load, then ack: load rd=7, sx_op=B; two cycles later ack with 0x000000F0 -> cycle after ack rf_we=1, rd=7, data=0xFFFFFFF0; lq_count returns 1->0.
- Collision: ack for pending rd=3 (UH, 0xABCD8001) in the same cycle as a non-load write rd=4 = 0x55 -> cycle+1 rd=3 data=0x00008001; stall_out and lid_rdy_out=0 for 1 cycle; cycle+2 rd=4 data=0x55.
- Full queue: LQ_DEPTH=2, two loads pending, third load presented -> stall_out=1 until an ack; the third load is accepted the cycle after the pop, and count stays 2.
- Spurious/rd0: ack with empty queue -> no write, err_out=1 sticky. Load to rd=0 then ack -> entry popped, rf_we_out=0. Assert rst mid-queue -> all outputs 0 and count 0 immediately.
- Hazard (macro defined): pending load rd=9, haz_rs2_in=9 -> haz_pend_out=1. haz_rs1_in=haz_rs2_in=10 -> haz_pend_out=0. Same stimulus with the macro undefined -> haz_pend_out=1 in both cases.
